// File: rtl/pwm_compare_unit_pkg.sv
// Shared definitions for the PWM compare unit: FSM state encoding
// and the default timer/duty word width.
package pwm_compare_unit_pkg;

    localparam int DEFAULT_WIDTH = 7;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } pwm_state_t;

endpackage

// File: rtl/pwm_compare_unit_wrap_detect.sv
// Timer wrap detector: flags the cycle where count drops below last cycle's value.
// Ports: clock, reset, count in; wrap (comb), period_start (registered wrap) out.
module pwm_compare_unit_wrap_detect
    import pwm_compare_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             period_start
);

    logic [WIDTH-1:0] prev_count;

    // prev_count resets to 0 so no count value can look like a wrap
    // until a real descending step is seen.
    assign wrap = (count < prev_count);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_count   <= '0;
            period_start <= 1'b0;
        end else begin
            prev_count   <= count;
            period_start <= wrap;
        end
    end

endmodule

// File: rtl/pwm_compare_unit.sv
// PWM compare unit: turns a free-running timer count into a PWM waveform with a
// double-buffered duty setpoint applied only at period boundaries.
// Ports: clock, reset (async, active-high), count, enable, duty_in, duty_load in;
//        pwm_out, period_start, duty_busy, duty_ack, active_duty out.
// Build option: define PWM_RAMP_EN to step active_duty by 1 per applying wrap.
module pwm_compare_unit
    import pwm_compare_unit_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter bit INVERT = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    input  logic             enable,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_load,
    output logic             pwm_out,
    output logic             period_start,
    output logic             duty_busy,
    output logic             duty_ack,
    output logic [WIDTH-1:0] active_duty
);

    pwm_state_t       state;
    pwm_state_t       state_next;
    logic             wrap;
    logic             compare_on;
    logic             apply;
    logic             done;
    logic             pwm_raw;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] duty_next;

    pwm_compare_unit_wrap_detect #(
        .WIDTH(WIDTH)
    ) u_wrap_detect (
        .clock        (clock),
        .reset        (reset),
        .count        (count),
        .wrap         (wrap),
        .period_start (period_start)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_OFF;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_OFF: begin
                if (enable) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (!enable)   state_next = ST_OFF;
                else if (wrap) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (enable)    state_next = ST_RUN;
                else if (wrap) state_next = ST_OFF;
            end
        endcase
    end

    // DRAIN drops the compare on the wrap cycle itself so the
    // finished period is not followed by a stray high clock.
    always_comb begin
        compare_on = 1'b0;
        apply      = 1'b0;
        unique case (state)
            ST_ARMED: begin
                apply = wrap && duty_busy;
            end
            ST_RUN: begin
                compare_on = 1'b1;
                apply      = wrap && duty_busy;
            end
            ST_DRAIN: begin
                compare_on = !wrap;
            end
            default: begin
                compare_on = 1'b0;
            end
        endcase
    end

    assign pwm_raw = compare_on && (count < active_duty);

`ifdef PWM_RAMP_EN
    always_comb begin
        duty_next = active_duty;
        if (pending > active_duty) begin
            duty_next = active_duty + 1'b1;
        end else if (pending < active_duty) begin
            duty_next = active_duty - 1'b1;
        end
    end
`else
    assign duty_next = pending;
`endif

    // Handshake completes once the active duty has reached the target.
    assign done = (duty_next == pending);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwm_out     <= INVERT;
            duty_ack    <= 1'b0;
            duty_busy   <= 1'b0;
            pending     <= '0;
            active_duty <= '0;
        end else begin
            pwm_out  <= pwm_raw ^ INVERT;
            duty_ack <= apply && done;
            if (apply) begin
                active_duty <= duty_next;
            end
            // A same-cycle load wins: the old target is applied,
            // the new one stays pending.
            if (duty_load) begin
                pending   <= duty_in;
                duty_busy <= 1'b1;
            end else if (apply && done) begin
                duty_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_compare_unit.sv
// Self-checking bench for pwm_compare_unit: lock-step reference model,
// table of duty/high-time vectors, directed corner sequences, random phase.
module tb_pwm_compare_unit;

    localparam int W    = 7;
    localparam int PER  = 1 << W;
    localparam int INV  = 0;

    logic         clock;
    logic         reset;
    logic [W-1:0] count;
    logic         enable;
    logic [W-1:0] duty_in;
    logic         duty_load;
    logic         pwm_out;
    logic         period_start;
    logic         duty_busy;
    logic         duty_ack;
    logic [W-1:0] active_duty;

    pwm_compare_unit #(
        .WIDTH  (W),
        .INVERT (1'b0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .count        (count),
        .enable       (enable),
        .duty_in      (duty_in),
        .duty_load    (duty_load),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .duty_busy    (duty_busy),
        .duty_ack     (duty_ack),
        .active_duty  (active_duty)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int tests;
    int failures;

    // Reference model: modes follow the behavioural description.
    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_ON   = 2;
    localparam int M_TAIL = 3;

    int m_prev;
    int m_mode;
    int m_pend;
    int m_act;
    int m_busy;
    int m_ack;
    int m_ps;
    int m_pwm;

    typedef struct {
        int duty;
        int high;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 0;
        m_mode = M_IDLE;
        m_pend = 0;
        m_act  = 0;
        m_busy = 0;
        m_ack  = 0;
        m_ps   = 0;
        m_pwm  = 0;
    endtask

    task automatic model_step();
        int c;
        int wrap;
        int cmp;
        int apply;
        int nact;
        int done;
        c     = int'(count);
        wrap  = (c < m_prev) ? 1 : 0;
        cmp   = (m_mode == M_ON || (m_mode == M_TAIL && wrap == 0)) ? 1 : 0;
        apply = (wrap != 0 && m_busy != 0 &&
                 (m_mode == M_WAIT || m_mode == M_ON)) ? 1 : 0;
        nact  = m_act;
        done  = 0;
        if (apply != 0) begin
`ifdef PWM_RAMP_EN
            if (m_pend > m_act) nact = m_act + 1;
            else if (m_pend < m_act) nact = m_act - 1;
`else
            nact = m_pend;
`endif
            done = (nact == m_pend) ? 1 : 0;
        end
        m_pwm = (cmp != 0 && c < m_act) ? 1 : 0;
        m_ack = (apply != 0 && done != 0) ? 1 : 0;
        m_act = nact;
        if (duty_load) begin
            m_pend = int'(duty_in);
            m_busy = 1;
        end else if (m_ack != 0) begin
            m_busy = 0;
        end
        case (m_mode)
            M_IDLE: if (enable) m_mode = M_WAIT;
            M_WAIT: begin
                if (!enable) m_mode = M_IDLE;
                else if (wrap != 0) m_mode = M_ON;
            end
            M_ON: if (!enable) m_mode = M_TAIL;
            default: begin
                if (enable) m_mode = M_ON;
                else if (wrap != 0) m_mode = M_IDLE;
            end
        endcase
        m_ps   = wrap;
        m_prev = c;
    endtask

    task automatic check_all();
        check("pwm_out", int'(pwm_out), m_pwm ^ INV);
        check("period_start", int'(period_start), m_ps);
        check("duty_busy", int'(duty_busy), m_busy);
        check("duty_ack", int'(duty_ack), m_ack);
        check("active_duty", int'(active_duty), m_act);
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset) model_step();
        #1;
        duty_load = 1'b0;
        count     = count + 7'd1;
        check_all();
    endtask

    task automatic run_to(input int c);
        while (int'(count) != c) tick();
    endtask

    task automatic load(input int d);
        duty_in   = W'(d);
        duty_load = 1'b1;
        tick();
    endtask

    task automatic measure(input int n, output int highs, output int rises);
        int prev;
        int cur;
        highs = 0;
        rises = 0;
        prev  = int'(pwm_out) ^ INV;
        for (int i = 0; i < n; i++) begin
            tick();
            cur = int'(pwm_out) ^ INV;
            highs += cur;
            if (cur == 1 && prev == 0) rises++;
            prev = cur;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_pwm", int'(pwm_out), INV);
        check("rst_busy", int'(duty_busy), 0);
        check("rst_active", int'(active_duty), 0);
        check("rst_ack", int'(duty_ack), 0);
        check("rst_ps", int'(period_start), 0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int h;
        int r;
        int acks;
        int ps_seen;

        vecs[0] = '{duty: 0,   high: 0};
        vecs[1] = '{duty: 127, high: 127};
        vecs[2] = '{duty: 1,   high: 1};
        vecs[3] = '{duty: 64,  high: 64};

        tests     = 0;
        failures  = 0;
        reset     = 1'b1;
        count     = 7'd5;
        enable    = 1'b0;
        duty_in   = '0;
        duty_load = 1'b0;
        model_reset();
        #1;
        check_all();
        tick();
        tick();
        reset = 1'b0;

        // First period: duty 32 loaded while armed.
        enable = 1'b1;
        run_to(10);
        load(32);
        check("t1_busy", int'(duty_busy), 1);
        run_to(0);
        tick();
        check("t1_ack", int'(duty_ack), 1);
        check("t1_active", int'(active_duty), 32);
        check("t1_ps", int'(period_start), 1);
        check("t1_pwm_low", int'(pwm_out), INV);
        tick();
        check("t1_pwm_rise", int'(pwm_out), 1 ^ INV);
        run_to(0);
        measure(PER, h, r);
        check("t1_high", h, 32);

        // Mid-period change to 100.
        run_to(40);
        load(100);
        check("t2_busy", int'(duty_busy), 1);
        run_to(0);
        tick();
        check("t2_busy_clr", int'(duty_busy), 0);
        check("t2_active", int'(active_duty), 100);
        run_to(0);
        measure(PER, h, r);
        check("t2_high", h, 100);

        // Two loads in one period: last wins, single ack.
        run_to(20);
        load(10);
        run_to(60);
        load(90);
        run_to(0);
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            acks += int'(duty_ack);
        end
        check("t3_acks", acks, 1);
        check("t3_active", int'(active_duty), 90);

        for (int v = 0; v < 4; v++) begin
            run_to(10);
            load(vecs[v].duty);
            run_to(0);
            tick();
            run_to(0);
            measure(PER, h, r);
            check("tab_high", h, vecs[v].high);
            check("tab_active", int'(active_duty), vecs[v].duty);
        end

        // Drain with duty 64, then off after the wrap.
        run_to(50);
        enable = 1'b0;
        run_to(0);
        tick();
        check("t5_off", int'(pwm_out), INV);
        measure(PER - 1, h, r);
        check("t5_off_high", h, 0);
        enable = 1'b1;
        run_to(0);
        tick();
        run_to(0);
        tick();
        run_to(50);
        enable = 1'b0;
        run_to(80);
        enable = 1'b1;
        measure(PER - 80, h, r);
        check("t5_rerun_rises", r, 0);
        measure(PER, h, r);
        check("t5_rerun_high", h, 64);
        check("t5_rerun_edges", r, 1);

        // Reset in RUN with a pending load.
        run_to(10);
        load(33);
        run_to(20);
        pulse_reset();
        ps_seen = 0;
        while (int'(count) != 0) begin
            tick();
            ps_seen += int'(period_start);
        end
        check("t6_no_ps", ps_seen, 0);
        tick();
        check("t6_ps_wrap", int'(period_start), 1);

`ifdef PWM_RAMP_EN
        pulse_reset();
        enable = 1'b1;
        load(5);
        for (int k = 1; k <= 6; k++) begin
            run_to(0);
            tick();
            check("ramp_active", int'(active_duty), (k < 5) ? k : 5);
            check("ramp_ack", int'(duty_ack), (k == 5) ? 1 : 0);
        end
`endif

        // Random phase against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) begin
                case ($urandom_range(3))
                    0: duty_in = '0;
                    1: duty_in = 7'd127;
                    default: duty_in = W'($urandom);
                endcase
                duty_load = 1'b1;
            end
            if ($urandom_range(149) == 0) enable = ~enable;
            if ($urandom_range(1999) == 0) pulse_reset();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/pwm_compare_unit.md
Name: pwm_compare_unit

Overview:
- Consumer of the free-running timer count; turns the counter value into a PWM waveform.
- Detects counter wrap to frame PWM periods.
- Double-buffers the duty setpoint so duty changes are applied only at period boundaries.
- Sits between the timer and the output driver (LED / motor pin).

Parameters:
- WIDTH, 7: width of timer count and duty words; period = 2^WIDTH clocks.
- INVERT, 0: when 1, pwm_out is active-low; all other outputs are unaffected.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- count  input  WIDTH  timer count, incrementing by 1 per clock and wrapping to 0.
- enable  input  1  run request (level).
- duty_in  input  WIDTH  requested high-time in clocks.
- duty_load  input  1  one-cycle strobe that captures duty_in into the pending register.
- pwm_out  output  1  registered PWM output.
- period_start  output  1  one-cycle pulse on the first clock of each period.
- duty_busy  output  1  high while a loaded duty is pending and not yet applied.
- duty_ack  output  1  one-cycle pulse when the pending duty becomes active.
- active_duty  output  WIDTH  duty currently in effect.

Behaviour:
- Reset values: pwm_out = INVERT, period_start = 0, duty_busy = 0, duty_ack = 0, active_duty = 0, pending = 0, prev_count = 0, state = OFF.
- Wrap detect: `wrap = (count < prev_count)`, with prev_count registered every clock. Mid-period resets therefore do not give false wraps once prev_count has been updated.
- period_start is the registered form of wrap, so it rises one clock after count reaches 0.
- FSM states:
  - OFF: pwm forced inactive. enable=1 -> ARMED.
  - ARMED: pwm inactive, waiting for wrap. wrap -> RUN (the pending duty is applied at this wrap). enable=0 -> OFF.
  - RUN: compare active. enable=0 -> DRAIN.
  - DRAIN: the current period finishes with the compare still active. wrap -> OFF, pwm inactive from that clock. enable=1 before the wrap -> back to RUN with no glitch.
- Compare (RUN/DRAIN): `pwm_raw = (count < active_duty)`, registered, so latency is 1 clock from count to pwm_out. Unsigned, WIDTH bits.
  - duty 0 -> constantly inactive.
  - duty 2^WIDTH-1 -> active for all but one clock per period; 100% is not representable.
- Handshake:
  - duty_load captures duty_in into pending and sets duty_busy on the next clock.
  - A load while busy overwrites pending (last write wins) and busy stays high.
  - At a wrap in ARMED or RUN with busy=1: active_duty <= pending, duty_ack pulses one clock, busy clears.
  - duty_load in the same cycle as an applying wrap: the old pending is applied and the new value stays pending (busy stays 1).
  - Wraps in OFF or DRAIN do not apply pending; it is held until the next ARMED/RUN wrap.
- enable toggles do not clear pending or active_duty. Only reset does.
- Reset asserted mid-period: all outputs go to reset values immediately (asynchronous). After release, state is OFF and prev_count = 0, so the first wrap detected is the next true wrap.

Optional Feature:
- Macro: PWM_RAMP_EN.
- Defined:
  - At each applying wrap, active_duty steps by ±1 toward pending instead of jumping.
  - duty_busy stays high until active_duty == pending.
  - duty_ack pulses only on the final step.
- Undefined: active_duty jumps directly to pending at the applying wrap.

Decomposition:
- Shared package: state encoding constants (OFF=2'd0, ARMED=2'd1, RUN=2'd2, DRAIN=2'd3) and the default WIDTH constant.
- One natural sub-module, wrap_detect: prev_count register plus comparator; outputs a wrap comb signal and the registered period_start.

Test Plan:
- Reset, then enable=1, duty_load with duty_in=32 before the first wrap, 7-bit timer -> duty_ack at the first wrap, active_duty=32, pwm_out high for exactly 32 of every 128 clocks, rising 2 clocks after count=0.
- Change duty_in to 100 mid-period -> duty_busy=1 until the next wrap; the current period keeps 32 high clocks; the next period has 100.
- Two loads (10, then 90) within one period -> single duty_ack; active_duty=90.
- duty 0 and duty 127 -> pwm_out constantly 0, and pwm_out 0 for exactly one clock per period, respectively.
- enable dropped at count=50 with duty 64 -> pwm completes its 64 high clocks and stays inactive after the wrap. Re-enable at count=80 of the same period -> stays in RUN with no extra edges.
- Reset pulse at count=20 in RUN -> pwm_out, duty_busy and active_duty return to 0 immediately; no period_start until the next true wrap.
- With PWM_RAMP_EN, load 5 from active 0 -> active_duty goes 1..5 over 5 wraps, and duty_ack fires only at 5.
